// File: rtl/wallace_pkg.sv
// Shared sizing helpers for the pipelined Wallace-tree multi-operand adder.
// Row counts, level counts and stage placement are all derived here.
package wallace_pkg;

    localparam int CSA_IN_ROWS = 3;

    function automatic int rows_after_level(input int n, input int k);
        int rows;
        rows = n;
        for (int i = 0; i < k; i++) begin
            rows = rows - rows / CSA_IN_ROWS;
        end
        return rows;
    endfunction

    function automatic int csa_levels(input int n);
        int rows;
        int lvl;
        rows = n;
        lvl  = 0;
        for (int i = 0; i < 64; i++) begin
            if (rows > 2) begin
                rows = rows - rows / CSA_IN_ROWS;
                lvl  = lvl + 1;
            end
        end
        return lvl;
    endfunction

    function automatic int out_width(input int wordlen, input int nops);
        return wordlen + $clog2(nops);
    endfunction

    function automatic int pipe_stages(input int levels, input int lps);
        return (levels + lps - 1) / lps;
    endfunction

    // A register closes every lps levels, and always after the last level.
    function automatic bit is_stage_boundary(input int level, input int levels, input int lps);
        return ((level % lps) == 0) || (level == levels);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the CSA levels and the final ripple CPA.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/wallace_adder_pipe_csa_level.sv
// One combinational carry-save level: rows are taken in threes and compressed
// into a sum row and a left-shifted carry row; leftover rows pass straight through.
module csa_level
    import wallace_pkg::*;
#(
    parameter int IN_ROWS = 3,
    parameter int W       = 8,
    localparam int OUT_ROWS = rows_after_level(IN_ROWS, 1)
) (
    input  logic [IN_ROWS*W-1:0]  in_rows,
    output logic [OUT_ROWS*W-1:0] out_rows
);

    localparam int GROUPS = IN_ROWS / CSA_IN_ROWS;
    localparam int PASS   = IN_ROWS - CSA_IN_ROWS * GROUPS;

    generate
        for (genvar g = 0; g < GROUPS; g++) begin : g_grp
            localparam int A_BASE = (3 * g) * W;
            localparam int B_BASE = (3 * g + 1) * W;
            localparam int C_BASE = (3 * g + 2) * W;
            localparam int S_BASE = (2 * g) * W;
            localparam int K_BASE = (2 * g + 1) * W;

            for (genvar b = 0; b < W - 1; b++) begin : g_bit
                full_adder u_fa (
                    .a  (in_rows[A_BASE + b]),
                    .b  (in_rows[B_BASE + b]),
                    .ci (in_rows[C_BASE + b]),
                    .s  (out_rows[S_BASE + b]),
                    .co (out_rows[K_BASE + b + 1])
                );
            end

            // The top column's carry would fall off the row, so only its sum is formed.
            assign out_rows[S_BASE + W - 1] = in_rows[A_BASE + W - 1] ^ in_rows[B_BASE + W - 1]
                                            ^ in_rows[C_BASE + W - 1];
            assign out_rows[K_BASE] = 1'b0;
        end

        for (genvar p = 0; p < PASS; p++) begin : g_pass
            assign out_rows[(2 * GROUPS + p) * W +: W] = in_rows[(3 * GROUPS + p) * W +: W];
        end
    endgenerate

endmodule

// File: rtl/wallace_adder_pipe.sv
// Pipelined multi-operand adder: operand extension, Wallace CSA tree with a
// register every LEVELS_PER_STAGE levels, then a registered ripple CPA. Global stall.
module wallace_adder_pipe
    import wallace_pkg::*;
#(
    parameter int WORDLEN          = 8,
    parameter int NUM_OPS          = 6,
    parameter int LEVELS_PER_STAGE = 1,
    parameter int OUT_WIDTH        = out_width(WORDLEN, NUM_OPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_OPS*WORDLEN-1:0] in_ops,
    input  logic                       in_signed,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_WIDTH-1:0]       out_sum
);

    localparam int LEVELS = csa_levels(NUM_OPS);
    localparam int STAGES = pipe_stages(LEVELS, LEVELS_PER_STAGE);
    localparam int VLD_W  = (STAGES > 0) ? STAGES : 1;
    localparam int EXT_W  = OUT_WIDTH - WORDLEN;

    logic                         advance_s;
    logic [NUM_OPS*OUT_WIDTH-1:0] ext_rows_s;
    logic [2*OUT_WIDTH-1:0]       cpa_rows_s;
    logic                         cpa_valid_s;
    logic [OUT_WIDTH-1:0]         cpa_sum_s;
    logic [OUT_WIDTH-1:0]         carry_s;
    logic [VLD_W-1:0]             vld_d, vld_q;
    logic                         out_valid_d, out_valid_q;
    logic [OUT_WIDTH-1:0]         out_sum_d, out_sum_q;

    assign advance_s = out_ready || !out_valid_q;
    assign in_ready  = advance_s;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

    // Widen every operand to the full result width (sign- or zero-extended).
    always_comb begin
        ext_rows_s = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (in_signed) begin
                ext_rows_s[k*OUT_WIDTH +: OUT_WIDTH] =
                    {{EXT_W{in_ops[k*WORDLEN + WORDLEN - 1]}}, in_ops[k*WORDLEN +: WORDLEN]};
            end else begin
                ext_rows_s[k*OUT_WIDTH +: OUT_WIDTH] =
                    {{EXT_W{1'b0}}, in_ops[k*WORDLEN +: WORDLEN]};
            end
        end
    end

    generate
        for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
            localparam int N_IN  = rows_after_level(NUM_OPS, j - 1);
            localparam int N_OUT = rows_after_level(NUM_OPS, j);

            logic [N_IN*OUT_WIDTH-1:0]  lvl_in_s;
            logic [N_OUT*OUT_WIDTH-1:0] lvl_out_s;
            logic [N_OUT*OUT_WIDTH-1:0] tap_s;

            if (j == 1) begin : g_src_ext
                assign lvl_in_s = ext_rows_s;
            end else begin : g_src_prev
                assign lvl_in_s = g_lvl[j-1].tap_s;
            end

            csa_level #(
                .IN_ROWS (N_IN),
                .W       (OUT_WIDTH)
            ) u_csa (
                .in_rows  (lvl_in_s),
                .out_rows (lvl_out_s)
            );

            if (is_stage_boundary(j, LEVELS, LEVELS_PER_STAGE)) begin : g_reg
                logic [N_OUT*OUT_WIDTH-1:0] data_d, data_q;

                // Stage data loads on advance and holds under stall.
                always_comb begin
                    if (advance_s) begin
                        data_d = lvl_out_s;
                    end else begin
                        data_d = data_q;
                    end
                end

                // Stage data register; contents are don't-care while invalid.
                always_ff @(posedge clk) begin
                    data_q <= data_d;
                end

                assign tap_s = data_q;
            end else begin : g_comb
                assign tap_s = lvl_out_s;
            end
        end

        if (LEVELS == 0) begin : g_no_tree
            assign cpa_rows_s = ext_rows_s;
        end else begin : g_tree
            assign cpa_rows_s = g_lvl[LEVELS].tap_s;
        end

        if (STAGES == 0) begin : g_vld_none
            assign cpa_valid_s = in_valid;
        end else begin : g_vld_pipe
            assign cpa_valid_s = vld_q[VLD_W-1];
        end

        assign carry_s[0] = 1'b0;
        for (genvar b = 0; b < OUT_WIDTH - 1; b++) begin : g_cpa
            full_adder u_fa (
                .a  (cpa_rows_s[b]),
                .b  (cpa_rows_s[OUT_WIDTH + b]),
                .ci (carry_s[b]),
                .s  (cpa_sum_s[b]),
                .co (carry_s[b + 1])
            );
        end
        assign cpa_sum_s[OUT_WIDTH-1] = cpa_rows_s[OUT_WIDTH-1] ^ cpa_rows_s[2*OUT_WIDTH-1]
                                      ^ carry_s[OUT_WIDTH-1];
    endgenerate

    // Valid bits shift with the data; a missing input becomes a bubble.
    always_comb begin
        vld_d = vld_q;
        if (advance_s) begin
            for (int i = VLD_W - 1; i > 0; i--) begin
                vld_d[i] = vld_q[i-1];
            end
            vld_d[0] = in_valid;
        end else begin
            vld_d = vld_q;
        end
    end

    // Output register only captures real results so out_sum never shows bubble garbage.
    always_comb begin
        if (advance_s && cpa_valid_s) begin
            out_sum_d = cpa_sum_s;
        end else begin
            out_sum_d = out_sum_q;
        end
        if (advance_s) begin
            out_valid_d = cpa_valid_s;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Control and output state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
        end
    end

endmodule

// File: tb/tb_wallace_adder_pipe.sv
// Scoreboard bench for wallace_adder_pipe: directed corners, streaming, stall,
// mid-flight reset on the default build, plus a small WORDLEN=4 parameter sweep.
module tb_wallace_adder_pipe;

    localparam int WL  = 8;
    localparam int NO  = 6;
    localparam int OW  = 11;
    localparam int LAT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [NO*WL-1:0] in_ops;
    logic            in_signed;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_sum;

    typedef struct {
        int exp;
        int acc_cyc;
    } sb_t;

    sb_t  sb_q[$];
    int   out_cyc_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   out_count = 0;
    bit   lat_mode  = 1'b0;
    bit   hold_v    = 1'b0;
    logic [OW-1:0] hold_sum;
    bit   sweep_go = 1'b0;
    int   sweep_finished = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    wallace_adder_pipe #(
        .WORDLEN          (WL),
        .NUM_OPS          (NO),
        .LEVELS_PER_STAGE (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ops    (in_ops),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Independent reference: extend each operand, sum as integers, wrap to ow bits.
    function automatic int ref_sum(input logic [127:0] ops, input bit sgn, input int n,
                                   input int wl, input int ow);
        int acc;
        int v;
        logic [127:0] mask;
        acc  = 0;
        mask = (128'd1 << wl) - 128'd1;
        for (int k = 0; k < n; k++) begin
            v = int'((ops >> (k * wl)) & mask);
            if (sgn && v >= (1 << (wl - 1))) v = v - (1 << wl);
            acc = acc + v;
        end
        return acc & ((1 << ow) - 1);
    endfunction

    function automatic int exp_lat(input int ci);
        case (ci)
            0: return 1;
            1: return 1;
            2: return 2;
            3: return 2;
            4: return 5;
            5: return 3;
            6: return 7;
            7: return 4;
            default: return 0;
        endcase
    endfunction

    // Output monitor: scoreboard compare, latency, and hold-under-stall checks.
    always @(negedge clk) begin
        sb_t item;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check_val("hold_valid", out_valid, 1);
                check_val("hold_sum", out_sum, hold_sum);
            end
            if (out_valid && out_ready) begin
                check_val("sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    item = sb_q.pop_front();
                    check_val("sum", out_sum, item.exp);
                    if (lat_mode) check_val("latency", cyc - item.acc_cyc, LAT);
                end
                out_count++;
                out_cyc_q.push_back(cyc);
            end
            hold_v   = out_valid && !out_ready;
            hold_sum = out_sum;
        end
    end

    task automatic send(input logic [NO*WL-1:0] ops, input bit sgn);
        bit done;
        logic [127:0] opsx;
        done      = 1'b0;
        opsx      = '0;
        opsx[NO*WL-1:0] = ops;
        in_ops    = ops;
        in_signed = sgn;
        in_valid  = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back('{exp: ref_sum(opsx, sgn, NO, WL, OW), acc_cyc: cyc});
                done = 1'b1;
            end
        end
        check_val("send_accepted", done, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic rand_ops(output logic [NO*WL-1:0] ops);
        logic [63:0] r;
        r   = {$urandom, $urandom};
        ops = r[NO*WL-1:0];
    endtask

    task automatic drain(input int target);
        for (int i = 0; i < 100 && (out_count < target || sb_q.size() != 0); i++) begin
            @(posedge clk);
            #2;
        end
        check_val("drain_count", out_count, target);
        check_val("sb_left", sb_q.size(), 0);
    endtask

    task automatic directed(input string tag, input logic [NO*WL-1:0] ops, input bit sgn,
                            input int exp);
        send(ops, sgn);
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check_val({tag, "_valid"}, out_valid, 1);
        check_val({tag, "_sum"}, out_sum, exp);
        drain(out_count + 1);
    endtask

    initial begin
        logic [NO*WL-1:0] ops;
        int base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ops    = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_sum", out_sum, 0);
        check_val("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        lat_mode = 1'b1;
        directed("umax", {6{8'hFF}}, 1'b0, 11'h5FA);
        directed("smin", {6{8'h80}}, 1'b1, 11'h500);
        directed("szero", {{3{8'hFF}}, {3{8'h01}}}, 1'b1, 0);

        // Back-to-back stream with the output always ready.
        base = out_count;
        out_cyc_q.delete();
        for (int i = 0; i < 20; i++) begin
            rand_ops(ops);
            send(ops, 1'($urandom_range(0, 1)));
        end
        drain(base + 20);
        check_val("stream_outs", out_cyc_q.size(), 20);
        if (out_cyc_q.size() == 20) check_val("stream_span", out_cyc_q[19] - out_cyc_q[0], 19);
        lat_mode = 1'b0;

        // Backpressure: ready for a few cycles, a 10-cycle stall on a full pipe, then random.
        base = out_count;
        fork
            begin
                logic [NO*WL-1:0] bops;
                for (int i = 0; i < 20; i++) begin
                    rand_ops(bops);
                    send(bops, 1'($urandom_range(0, 1)));
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    #1;
                    if (i < 6) begin
                        out_ready = 1'b1;
                    end else if (i < 16) begin
                        out_ready = 1'b0;
                        @(negedge clk);
                        check_val("stall_in_ready", in_ready, 0);
                    end else begin
                        out_ready = 1'($urandom_range(0, 1));
                    end
                end
                out_ready = 1'b1;
            end
        join
        drain(base + 20);

        // Reset while three transactions are in flight.
        base = out_count;
        for (int i = 0; i < 3; i++) begin
            rand_ops(ops);
            send(ops | 48'h1, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_out_sum", out_sum, 0);
        repeat (8) @(posedge clk);
        #1;
        check_val("midrst_discard", out_count, base);
        lat_mode = 1'b1;
        directed("post_rst", {6{8'h01}}, 1'b0, 6);
        lat_mode = 1'b0;

        // Parameter sweep runs after the default build is done.
        sweep_go = 1'b1;
        for (int i = 0; i < 2000 && sweep_finished < 8; i++) @(posedge clk);
        check_val("sweep_done", sweep_finished, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    generate
        for (genvar ci = 0; ci < 8; ci++) begin : g_sweep
            localparam int SNO  = (ci / 2 == 0) ? 2 : (ci / 2 == 1) ? 3 : (ci / 2 == 2) ? 8 : 16;
            localparam int SLPS = (ci % 2) + 1;
            localparam int SOW  = 4 + $clog2(SNO);
            localparam int SN   = 24;

            logic             s_in_valid;
            logic             s_in_ready;
            logic             s_in_signed;
            logic [SNO*4-1:0] s_in_ops;
            logic             s_out_valid;
            logic [SOW-1:0]   s_out_sum;

            wallace_adder_pipe #(
                .WORDLEN          (4),
                .NUM_OPS          (SNO),
                .LEVELS_PER_STAGE (SLPS)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (s_in_valid),
                .in_ready  (s_in_ready),
                .in_ops    (s_in_ops),
                .in_signed (s_in_signed),
                .out_valid (s_out_valid),
                .out_ready (1'b1),
                .out_sum   (s_out_sum)
            );

            initial begin
                int q[$];
                int first_acc;
                int first_out;
                int n_out;
                logic [127:0] ops;
                bit sgn;
                first_acc   = -1;
                first_out   = -1;
                n_out       = 0;
                ops         = '0;
                sgn         = 1'b0;
                s_in_valid  = 1'b0;
                s_in_ops    = '0;
                s_in_signed = 1'b0;
                wait (sweep_go);
                for (int i = 0; i < SN + exp_lat(ci) + 4; i++) begin
                    @(posedge clk);
                    #1;
                    if (i < SN) begin
                        if (i == 0) begin
                            ops = '1;
                            sgn = 1'b0;
                        end else if (i == 1) begin
                            ops = {32{4'h8}};
                            sgn = 1'b1;
                        end else if (i == 2) begin
                            ops = '1;
                            sgn = 1'b1;
                        end else begin
                            ops = {64'd0, $urandom, $urandom};
                            sgn = 1'($urandom_range(0, 1));
                        end
                        s_in_ops    = ops[SNO*4-1:0];
                        s_in_signed = sgn;
                        s_in_valid  = 1'b1;
                    end else begin
                        s_in_valid = 1'b0;
                    end
                    @(negedge clk);
                    if (s_out_valid) begin
                        check_val($sformatf("sweep%0d_nonempty", ci), q.size() > 0, 1);
                        if (q.size() > 0) check_val($sformatf("sweep%0d_sum", ci), s_out_sum, q.pop_front());
                        if (first_out < 0) first_out = cyc;
                        n_out++;
                    end
                    if (s_in_valid && s_in_ready) begin
                        q.push_back(ref_sum(ops, sgn, SNO, 4, SOW));
                        if (first_acc < 0) first_acc = cyc;
                    end
                end
                check_val($sformatf("sweep%0d_latency", ci), first_out - first_acc, exp_lat(ci));
                check_val($sformatf("sweep%0d_count", ci), n_out, SN);
                sweep_finished++;
            end
        end
    endgenerate

endmodule
